// File: rtl/fixed_att_pkg.sv
// rtl/fixed_att_pkg.sv - shared types, widths and helpers for the self-attention input scheduler
package fixed_att_pkg;

    typedef enum logic [1:0] {
        ACCEPT  = 2'd0,
        PARTIAL = 2'd1,
        STALL   = 2'd2
    } sched_state_t;

    localparam int FRAMES_W = 3;

    function automatic int in_beats_f(input int num_parallelism, input int depth);
        return num_parallelism * depth;
    endfunction

    // Counter width that stays legal for a count of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fork3_taken.sv
// rtl/fork3_taken.sv - 3-way broadcast handshake; each branch takes a beat exactly once
module fork3_taken (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    output logic q_valid,
    output logic k_valid,
    output logic v_valid,
    input  logic q_ready,
    input  logic k_ready,
    input  logic v_ready,
    output logic any_taken,
    output logic any_fire
);

    logic [2:0] taken;
    logic [2:0] valid;
    logic [2:0] ready;
    logic [2:0] fire;

    assign valid = {3{in_valid}} & ~taken;
    assign ready = {v_ready, k_ready, q_ready};
    assign fire  = valid & ready;

    // The beat is done once every branch has either taken it earlier or takes it now.
    assign in_ready  = in_valid && ((taken | fire) == 3'b111);
    assign q_valid   = valid[0];
    assign k_valid   = valid[1];
    assign v_valid   = valid[2];
    assign any_taken = |taken;
    assign any_fire  = |fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taken <= '0;
        end else if (in_ready) begin
            taken <= '0;
        end else begin
            taken <= taken | fire;
        end
    end

endmodule

// File: rtl/fixed_self_att_scheduler.sv
// rtl/fixed_self_att_scheduler.sv - Q/K/V input fork with frame credit; SELF_ATT_SCHED_PERF_EN adds perf counters
module fixed_self_att_scheduler
    import fixed_att_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int IN_PARALLELISM     = 3,
    parameter int IN_SIZE            = 3,
    parameter int IN_NUM_PARALLELISM = 2,
    parameter int IN_DEPTH           = 3,
    parameter int OUT_BEATS          = 6,
    parameter int MAX_FRAMES         = 1,
    localparam int IN_BEATS = in_beats_f(IN_NUM_PARALLELISM, IN_DEPTH),
    localparam int IDX_W    = cnt_w(IN_BEATS),
    localparam int BLK_W    = DATA_WIDTH * IN_PARALLELISM * IN_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BLK_W-1:0]   data_in_0,
    input  logic               data_in_0_valid,
    output logic               data_in_0_ready,
    output logic [BLK_W-1:0]   data_in_q,
    output logic [BLK_W-1:0]   data_in_k,
    output logic [BLK_W-1:0]   data_in_v,
    output logic               data_in_q_valid,
    output logic               data_in_k_valid,
    output logic               data_in_v_valid,
    input  logic               data_in_q_ready,
    input  logic               data_in_k_ready,
    input  logic               data_in_v_ready,
    input  logic               out_tap_valid,
    input  logic               out_tap_ready,
    output logic [IDX_W-1:0]   in_beat_idx,
    output logic [FRAMES_W-1:0] frames_in_flight,
    output logic               busy
`ifdef SELF_ATT_SCHED_PERF_EN
    ,
    output logic [31:0]        perf_stall_cycles,
    output logic [15:0]        perf_frames
`endif
);

    localparam int OUT_W = cnt_w(OUT_BEATS);
    localparam logic [FRAMES_W-1:0] MAX_F    = FRAMES_W'(MAX_FRAMES);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(IN_BEATS - 1);
    localparam logic [OUT_W-1:0]    OUT_LAST = OUT_W'(OUT_BEATS - 1);

    sched_state_t state, state_next;
    logic [FRAMES_W-1:0] fif_next;
    logic [OUT_W-1:0]    out_cnt;
    logic credit, credit_next, allow;
    logic beat_done, any_taken, any_fire;
    logic inc, dec, tap;

    assign data_in_q = data_in_0;
    assign data_in_k = data_in_0;
    assign data_in_v = data_in_0;

    assign credit = frames_in_flight < MAX_F;
    // A beat already started must finish even if credit has gone away.
    assign allow  = credit || (state == PARTIAL);

    fork3_taken u_fork (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (data_in_0_valid && allow),
        .in_ready  (beat_done),
        .q_valid   (data_in_q_valid),
        .k_valid   (data_in_k_valid),
        .v_valid   (data_in_v_valid),
        .q_ready   (data_in_q_ready),
        .k_ready   (data_in_k_ready),
        .v_ready   (data_in_v_ready),
        .any_taken (any_taken),
        .any_fire  (any_fire)
    );

    assign data_in_0_ready = beat_done;
    assign tap = out_tap_valid && out_tap_ready;
    assign inc = beat_done && (in_beat_idx == IDX_LAST);
    assign dec = tap && (out_cnt == OUT_LAST);
    assign busy = (frames_in_flight != '0) || any_taken;

    always_comb begin
        fif_next = frames_in_flight;
        if (inc && !dec && (frames_in_flight != '1)) begin
            fif_next = frames_in_flight + FRAMES_W'(1);
        end else if (dec && !inc && (frames_in_flight != '0)) begin
            fif_next = frames_in_flight - FRAMES_W'(1);
        end
    end

    assign credit_next = fif_next < MAX_F;

    always_comb begin
        state_next = state;
        unique case (state)
            ACCEPT: begin
                if (beat_done) begin
                    state_next = credit_next ? ACCEPT : STALL;
                end else if (any_fire) begin
                    state_next = PARTIAL;
                end else if (!credit_next) begin
                    state_next = STALL;
                end
            end
            PARTIAL: begin
                if (beat_done) begin
                    state_next = credit_next ? ACCEPT : STALL;
                end
            end
            STALL: begin
                if (credit_next) begin
                    state_next = ACCEPT;
                end
            end
            default: state_next = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ACCEPT;
            in_beat_idx      <= '0;
            out_cnt          <= '0;
            frames_in_flight <= '0;
        end else begin
            state            <= state_next;
            frames_in_flight <= fif_next;
            if (beat_done) begin
                in_beat_idx <= (in_beat_idx == IDX_LAST) ? '0 : in_beat_idx + IDX_W'(1);
            end
            if (tap) begin
                out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + OUT_W'(1);
            end
        end
    end

    // An output frame finishing with nothing in flight means the core and scheduler disagree.
    underflow_chk: assert property (@(posedge clk) disable iff (!rst)
        !(dec && !inc && (frames_in_flight == '0)));

`ifdef SELF_ATT_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cycles <= '0;
            perf_frames       <= '0;
        end else begin
            if (data_in_0_valid && (state == STALL) && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (inc) begin
                perf_frames <= perf_frames + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fixed_self_att_scheduler.sv
// tb/tb_fixed_self_att_scheduler.sv - scoreboard bench for the Q/K/V input scheduler
module tb_fixed_self_att_scheduler;
    import fixed_att_pkg::*;

    localparam int BW = 72;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [BW-1:0] din = '0;
    logic din_valid = 1'b0;
    logic q_ready = 1'b0, k_ready = 1'b0, v_ready = 1'b0;
    logic tap_valid = 1'b0, tap_ready = 1'b0;

    logic din_ready, q_valid, k_valid, v_valid, busy;
    logic [BW-1:0] q_data, k_data, v_data;
    logic [2:0] idx, fif;
    logic din_ready2, q_valid2, k_valid2, v_valid2, busy2;
    logic [BW-1:0] q_data2, k_data2, v_data2;
    logic [2:0] idx2, fif2;
`ifdef SELF_ATT_SCHED_PERF_EN
    logic [31:0] perf_stall, perf_stall2;
    logic [15:0] perf_frames, perf_frames2;
`endif

    int checks = 0;
    int failures = 0;
    int hs_q = 0, hs_k = 0, hs_v = 0;
    logic [BW-1:0] q_exp[$];
    logic [BW-1:0] k_exp[$];
    logic [BW-1:0] v_exp[$];

    always #5 clk = ~clk;

    fixed_self_att_scheduler dut (
        .clk(clk), .rst(rst),
        .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(din_ready),
        .data_in_q(q_data), .data_in_k(k_data), .data_in_v(v_data),
        .data_in_q_valid(q_valid), .data_in_k_valid(k_valid), .data_in_v_valid(v_valid),
        .data_in_q_ready(q_ready), .data_in_k_ready(k_ready), .data_in_v_ready(v_ready),
        .out_tap_valid(tap_valid), .out_tap_ready(tap_ready),
        .in_beat_idx(idx), .frames_in_flight(fif), .busy(busy)
`ifdef SELF_ATT_SCHED_PERF_EN
        , .perf_stall_cycles(perf_stall), .perf_frames(perf_frames)
`endif
    );

    fixed_self_att_scheduler #(.MAX_FRAMES(2)) dut2 (
        .clk(clk), .rst(rst),
        .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(din_ready2),
        .data_in_q(q_data2), .data_in_k(k_data2), .data_in_v(v_data2),
        .data_in_q_valid(q_valid2), .data_in_k_valid(k_valid2), .data_in_v_valid(v_valid2),
        .data_in_q_ready(q_ready), .data_in_k_ready(k_ready), .data_in_v_ready(v_ready),
        .out_tap_valid(tap_valid), .out_tap_ready(tap_ready),
        .in_beat_idx(idx2), .frames_in_flight(fif2), .busy(busy2)
`ifdef SELF_ATT_SCHED_PERF_EN
        , .perf_stall_cycles(perf_stall2), .perf_frames(perf_frames2)
`endif
    );

    // Branch monitors: every handshake must consume exactly one expected beat.
    always @(negedge clk) begin
        logic [BW-1:0] e;
        if (rst && q_valid && q_ready) begin
            hs_q++;
            checks++;
            if (q_exp.size() == 0) begin
                failures++;
                $display("FAIL q_dup_beat got=%h required=none", q_data);
            end else begin
                e = q_exp.pop_front();
                if (q_data !== e) begin
                    failures++;
                    $display("FAIL q_data got=%h required=%h", q_data, e);
                end
            end
        end
        if (rst && k_valid && k_ready) begin
            hs_k++;
            checks++;
            if (k_exp.size() == 0) begin
                failures++;
                $display("FAIL k_dup_beat got=%h required=none", k_data);
            end else begin
                e = k_exp.pop_front();
                if (k_data !== e) begin
                    failures++;
                    $display("FAIL k_data got=%h required=%h", k_data, e);
                end
            end
        end
        if (rst && v_valid && v_ready) begin
            hs_v++;
            checks++;
            if (v_exp.size() == 0) begin
                failures++;
                $display("FAIL v_dup_beat got=%h required=none", v_data);
            end else begin
                e = v_exp.pop_front();
                if (v_data !== e) begin
                    failures++;
                    $display("FAIL v_data got=%h required=%h", v_data, e);
                end
            end
        end
    end

    function automatic logic [BW-1:0] rnd();
        return BW'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic clear_sb();
        q_exp.delete();
        k_exp.delete();
        v_exp.delete();
        hs_q = 0;
        hs_k = 0;
        hs_v = 0;
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        tap_valid = 1'b0;
        tap_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_sb();
    endtask

    // Offers one beat; lat is the number of cycles before the beat completed.
    task automatic send_beat(input logic [BW-1:0] d, input bit use2, output int lat);
        din = d;
        din_valid = 1'b1;
        q_exp.push_back(d);
        k_exp.push_back(d);
        v_exp.push_back(d);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if ((use2 ? din_ready2 : din_ready) === 1'b1) begin
                lat = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (q_valid !== 1'b0 || k_valid !== 1'b0 || v_valid !== 1'b0 || din_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake got=%b%b%b%b required=0000", q_valid, k_valid, v_valid, din_ready);
        end
        checks++;
        if (idx !== 3'd0 || fif !== 3'd0 || busy !== 1'b0 || dut.state !== ACCEPT) begin
            failures++;
            $display("FAIL reset_state got idx=%0d fif=%0d busy=%b st=%0d required 0 0 0 0", idx, fif, busy, dut.state);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_sb();
    endtask

    task automatic test_back_to_back();
        int lat;
        q_ready = 1'b1;
        k_ready = 1'b1;
        v_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_beat(rnd(), 1'b0, lat);
            checks++;
            if (lat != 0) begin
                failures++;
                $display("FAIL b2b_latency beat=%0d got=%0d required=0", i, lat);
            end
            checks++;
            if (idx !== 3'((i + 1) % 6)) begin
                failures++;
                $display("FAIL b2b_idx beat=%0d got=%0d required=%0d", i, idx, (i + 1) % 6);
            end
            checks++;
            if (fif !== ((i == 5) ? 3'd1 : 3'd0)) begin
                failures++;
                $display("FAIL b2b_fif beat=%0d got=%0d required=%0d", i, fif, (i == 5) ? 1 : 0);
            end
        end
        din = rnd();
        q_exp.push_back(din);
        k_exp.push_back(din);
        v_exp.push_back(din);
        din_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (din_ready !== 1'b0 || q_valid !== 1'b0 || k_valid !== 1'b0 || v_valid !== 1'b0 || dut.state !== STALL) begin
            failures++;
            $display("FAIL b2b_stall got rdy=%b qkv=%b%b%b st=%0d required rdy=0 qkv=000 st=%0d",
                     din_ready, q_valid, k_valid, v_valid, dut.state, STALL);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall_release();
        tap_valid = 1'b1;
        tap_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            checks++;
            if (fif !== 3'd1 || din_ready !== 1'b0) begin
                failures++;
                $display("FAIL release_hold tap=%0d got fif=%0d rdy=%b required fif=1 rdy=0", t, fif, din_ready);
            end
            @(posedge clk);
            #1;
        end
        tap_valid = 1'b0;
        tap_ready = 1'b0;
        checks++;
        if (fif !== 3'd0 || dut.state !== ACCEPT) begin
            failures++;
            $display("FAIL release_credit got fif=%0d st=%0d required fif=0 st=%0d", fif, dut.state, ACCEPT);
        end
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_accept got=%b required=1", din_ready);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        checks++;
        if (idx !== 3'd1 || q_exp.size() != 0) begin
            failures++;
            $display("FAIL release_idx got idx=%0d pending=%0d required idx=1 pending=0", idx, q_exp.size());
        end
    endtask

    task automatic test_partial_take();
        do_reset();
        q_ready = 1'b1;
        k_ready = 1'b0;
        v_ready = 1'b1;
        din = rnd();
        q_exp.push_back(din);
        k_exp.push_back(din);
        v_exp.push_back(din);
        din_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (k_valid !== 1'b1 || din_ready !== 1'b0) begin
                failures++;
                $display("FAIL partial_k cycle=%0d got kv=%b rdy=%b required kv=1 rdy=0", c, k_valid, din_ready);
            end
            if (c > 0) begin
                checks++;
                if (q_valid !== 1'b0 || v_valid !== 1'b0 || dut.state !== PARTIAL) begin
                    failures++;
                    $display("FAIL partial_taken cycle=%0d got qv=%b vv=%b st=%0d required 0 0 %0d",
                             c, q_valid, v_valid, dut.state, PARTIAL);
                end
            end
            @(posedge clk);
            #1;
        end
        k_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b1) begin
            failures++;
            $display("FAIL partial_complete got=%b required=1", din_ready);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        checks++;
        if (hs_q != 1 || hs_k != 1 || hs_v != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL partial_once got q=%0d k=%0d v=%0d busy=%b required 1 1 1 0", hs_q, hs_k, hs_v, busy);
        end
    endtask

    task automatic test_reset_partial();
        logic [BW-1:0] d;
        q_ready = 1'b1;
        k_ready = 1'b0;
        v_ready = 1'b0;
        d = rnd();
        din = d;
        q_exp.push_back(d);
        k_exp.push_back(d);
        v_exp.push_back(d);
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dut.state !== PARTIAL || busy !== 1'b1 || q_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstp_pre got st=%0d busy=%b qv=%b required %0d 1 0", dut.state, busy, q_valid, PARTIAL);
        end
        q_ready = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || idx !== 3'd0 || fif !== 3'd0 || dut.state !== ACCEPT || q_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstp_clear got busy=%b idx=%0d fif=%0d st=%0d qv=%b required 0 0 0 0 1",
                     busy, idx, fif, dut.state, q_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_sb();
        q_exp.push_back(d);
        k_exp.push_back(d);
        v_exp.push_back(d);
        q_ready = 1'b1;
        k_ready = 1'b1;
        v_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstp_redeliver got=%b required=1", din_ready);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        checks++;
        if (hs_q != 1 || hs_k != 1 || hs_v != 1) begin
            failures++;
            $display("FAIL rstp_all_three got q=%0d k=%0d v=%0d required 1 1 1", hs_q, hs_k, hs_v);
        end
    endtask

    task automatic test_simultaneous();
        int lat;
        do_reset();
        q_ready = 1'b1;
        k_ready = 1'b1;
        v_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            send_beat(rnd(), 1'b1, lat);
            checks++;
            if (lat != 0) begin
                failures++;
                $display("FAIL simul_latency beat=%0d got=%0d required=0", i, lat);
            end
        end
        tap_valid = 1'b1;
        tap_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (fif2 !== 3'd1 || idx2 !== 3'd5) begin
            failures++;
            $display("FAIL simul_pre got fif=%0d idx=%0d required 1 5", fif2, idx2);
        end
        din = rnd();
        din_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (din_ready2 !== 1'b1) begin
            failures++;
            $display("FAIL simul_accept got=%b required=1", din_ready2);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        tap_valid = 1'b0;
        tap_ready = 1'b0;
        checks++;
        if (fif2 !== 3'd1 || idx2 !== 3'd0 || fif !== 3'd0) begin
            failures++;
            $display("FAIL simul_fif got fif2=%0d idx2=%0d fif=%0d required 1 0 0", fif2, idx2, fif);
        end
        clear_sb();
    endtask

`ifdef SELF_ATT_SCHED_PERF_EN
    task automatic test_perf();
        int lat;
        do_reset();
        q_ready = 1'b1;
        k_ready = 1'b1;
        v_ready = 1'b1;
        for (int i = 0; i < 6; i++) send_beat(rnd(), 1'b0, lat);
        checks++;
        if (perf_frames !== 16'd1) begin
            failures++;
            $display("FAIL perf_frames got=%0d required=1", perf_frames);
        end
        q_ready = 1'b0;
        k_ready = 1'b0;
        v_ready = 1'b0;
        din_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        din_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (perf_stall !== 32'd10) begin
            failures++;
            $display("FAIL perf_stall got=%0d required=10", perf_stall);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_stall_release();
        test_partial_take();
        test_reset_partial();
        test_simultaneous();
`ifdef SELF_ATT_SCHED_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fixed_self_att_scheduler.md
Name: fixed_self_att_scheduler

Overview:
Input-side sequencer for the fixed-point self-attention datapath. Forks one data_in_0 stream into the Q, K and V projection branches with per-branch "taken" tracking, so the branches need not be ready in the same cycle. Counts beats per frame and limits frames in flight by tapping the attention output handshake. Sits between the upstream producer and the three branch inputs of the attention core.

Parameters:
DATA_WIDTH, 8, element width of the input block
IN_PARALLELISM, 3, rows per input block
IN_SIZE, 3, columns per input block
IN_NUM_PARALLELISM, 2, row-blocks per frame
IN_DEPTH, 3, column-blocks per frame; IN_BEATS = IN_NUM_PARALLELISM*IN_DEPTH (default 6)
OUT_BEATS, 6, output beats per frame at data_out_0
MAX_FRAMES, 1, frames allowed in flight (1..7)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
data_in_0  in  DATA_WIDTH x IN_PARALLELISM*IN_SIZE  upstream block
data_in_0_valid  in  1  upstream valid
data_in_0_ready  out  1  upstream ready
data_in_q / data_in_k / data_in_v  out  DATA_WIDTH x IN_PARALLELISM*IN_SIZE  branch data; each is data_in_0 passed through combinationally
data_in_q_valid / data_in_k_valid / data_in_v_valid  out  1  per-branch valid
data_in_q_ready / data_in_k_ready / data_in_v_ready  in  1  per-branch ready
out_tap_valid, out_tap_ready  in  1  copies of the core data_out_0 valid/ready (observe only)
in_beat_idx  out  $clog2(IN_BEATS)  index of the current input beat in the frame
frames_in_flight  out  3  accepted frames not yet fully emitted
busy  out  1  frames_in_flight!=0, or a beat is partially taken

Behaviour:
- Reset (rst=0, asynchronous): all taken flags, in_beat_idx, out counter and frames_in_flight cleared; state ACCEPT. Outputs after reset: all valids 0 and data_in_0_ready 0 until data_in_0_valid is seen; busy 0.
- credit = (frames_in_flight < MAX_FRAMES).
- States:
  - ACCEPT: no branch has taken the current beat.
  - PARTIAL: at least one branch has taken the current beat, not all.
  - STALL: credit=0 and the current beat is untaken.
- Branch valid: x_valid = data_in_0_valid && !taken_x && (credit || state==PARTIAL). A beat already started always finishes even if credit drops.
- Beat completes when, for every branch x, taken_x || (x_valid && x_ready).
- data_in_0_ready = 1 exactly in the cycle the beat completes. Zero-latency combinational fork; no data register.
- On a branch accept without beat completion: set taken_x. On beat completion: clear all taken flags.
- On beat completion, in_beat_idx wraps at IN_BEATS-1 back to 0. At the wrap, frames_in_flight increments.
- Output tap: an out counter counts out_tap_valid&&out_tap_ready beats. At OUT_BEATS-1 it wraps to 0 and frames_in_flight decrements.
- Increment and decrement in the same cycle leave frames_in_flight unchanged.
- A decrement at 0 must not underflow: the value saturates at 0 and the event is a protocol error, caught by an assertion.
- A frame's last beat is accepted before the credit check for the next frame; the first beat of the next frame sees the updated count one cycle later.
- Upstream must keep data stable while valid && !ready; the block relies on this because the fork is unregistered.
- State transitions:
  - ACCEPT->PARTIAL on a partial take.
  - PARTIAL->ACCEPT or STALL on completion, chosen by next-cycle credit.
  - STALL->ACCEPT when credit returns.

Optional Feature:
Macro SELF_ATT_SCHED_PERF_EN.
- Defined: adds output perf_stall_cycles [31:0] and output perf_frames [15:0].
  - perf_stall_cycles increments every cycle that data_in_0_valid=1 and state==STALL; it saturates at all-ones.
  - perf_frames counts completed input frames and wraps.
  - Both reset to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fixed_att_pkg:
  - sched_state_t enum {ACCEPT, PARTIAL, STALL};
  - FRAMES_W=3 localparam;
  - the IN_BEATS helper function.
- Sub-module fork3_taken: 3-way broadcast handshake with taken flags, instantiated once.
- Top-level logic: counters, credit, FSM.

Test Plan:
- All branches ready, 6 back-to-back valid beats -> ready on each beat; frames_in_flight 0->1 after beat 5; beat 7 held, state STALL.
- k_ready low for 3 cycles on beat 0 -> q and v taken once (a single handshake each); k_valid stays high; data_in_0_ready pulses only when k accepts; no branch gets a duplicate.
- Stall with MAX_FRAMES=1: after 6 out_tap handshakes, frames_in_flight 1->0 and STALL->ACCEPT; next beat accepted the following cycle.
- Simultaneous last input beat and last output beat with frames_in_flight=1 -> stays 1.
- rst asserted while in PARTIAL with taken_q=1 -> flags, counters and FSM clear immediately; after release, the same beat is re-delivered to all three branches.
- With SELF_ATT_SCHED_PERF_EN, hold valid for 10 cycles in STALL -> perf_stall_cycles==10, and perf_frames==1 after one frame.
